// File: rtl/div_unit.sv
// div_unit: sequential signed divider, restoring shift-subtract.
// Accepts an operand pair on start, iterates once per clock for WIDTH
// cycles, then applies result signs and pulses done. Divide-by-zero is
// reported immediately from IDLE with done+div_zero and no iteration.
// Remainder is presented on hi, quotient on lo.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH:0]   w_rem_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

    // Operand magnitudes (plain two's-complement negation, so the most
    // negative value maps onto itself as an unsigned magnitude) and the
    // per-iteration restoring step.
    always_comb begin
        w_abs_dvd   = dividend[WIDTH-1] ? -dividend : dividend;
        w_abs_dvs   = divisor[WIDTH-1]  ? -divisor  : divisor;
        w_rem_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_d});
        w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_d}) : w_rem_shift;
        w_q_next    = {r_q[WIDTH-2:0], w_ge};
        w_lo_fix    = r_sign_q ? -r_q : r_q;
        w_hi_fix    = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_d        <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                            r_q      <= w_abs_dvd;
                            r_d      <= w_abs_dvs;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_lo_fix;
                    r_hi    <= w_hi_fix;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a
// cycle-level behavioural model built on the language's signed / and %.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
    localparam logic [W-1:0] NEG1 = 32'hFFFF_FFFF;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_cmp   = 0;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: truncating signed division, remainder follows the
    // dividend; the single overflowing pair has a fixed answer.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (a == MIN && b == NEG1) begin
            q = MIN;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Cycle-level model: an accepted request completes W+1 edges later.
    logic         m_busy = 0, m_done = 0, m_dz = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_q = '0, p_r = '0;
    int           m_cnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_cnt = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_hi   = p_r;
                    m_lo   = p_q;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    m_done = 1;
                    m_dz   = 1;
                end else begin
                    ref_div(dividend, divisor, p_q, p_r);
                    m_busy = 1;
                    m_cnt  = W + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (en_cmp) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles", lat);
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        case ($urandom % 8)
            0: v = '0;
            1: v = MIN;
            2: v = NEG1;
            3: v = W'($urandom_range(1, 20));
            4: v = -W'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [W-1:0] tq, tr;
    int lat, ndone;

    initial begin
        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        // Model self-pins against hand-computed answers.
        ref_div(32'd7, 32'd2, tq, tr);             chk("ref 7/2 q", tq, 32'd3);       chk("ref 7/2 r", tr, 32'd1);
        ref_div(32'hFFFF_FFF9, 32'd2, tq, tr);     chk("ref -7/2 q", tq, 32'hFFFF_FFFD); chk("ref -7/2 r", tr, NEG1);
        ref_div(32'd7, 32'hFFFF_FFFE, tq, tr);     chk("ref 7/-2 q", tq, 32'hFFFF_FFFD); chk("ref 7/-2 r", tr, 32'd1);
        ref_div(MIN, NEG1, tq, tr);                chk("ref min/-1 q", tq, MIN);      chk("ref min/-1 r", tr, 32'd0);

        tick(); tick();
        en_cmp = 1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        // 7 / 2
        start_op(32'd7, 32'd2);
        chk("busy after start", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("latency 7/2", lat, 32'd33);
        chk("7/2 lo", lo, 32'd3);
        chk("7/2 hi", hi, 32'd1);
        tick();
        chk("done one cycle", {31'd0, done}, 32'd0);

        // divide by zero keeps the previous result
        start_op(32'd55, 32'd0);
        chk("dz done", {31'd0, done}, 32'd1);
        chk("dz flag", {31'd0, div_zero}, 32'd1);
        chk("dz busy", {31'd0, busy}, 32'd0);
        chk("dz lo", lo, 32'd3);
        chk("dz hi", hi, 32'd1);
        tick();
        chk("dz pulse", {31'd0, div_zero}, 32'd0);

        // signed cases
        start_op(32'hFFFF_FFF9, 32'd2); wait_done(lat);
        chk("-7/2 lo", lo, 32'hFFFF_FFFD); chk("-7/2 hi", hi, NEG1);
        start_op(32'd7, 32'hFFFF_FFFE); wait_done(lat);
        chk("7/-2 lo", lo, 32'hFFFF_FFFD); chk("7/-2 hi", hi, 32'd1);
        start_op(MIN, NEG1); wait_done(lat);
        chk("ovf lo", lo, MIN); chk("ovf hi", hi, 32'd0);
        chk("ovf dz", {31'd0, div_zero}, 32'd0);
        start_op(MIN, 32'd1); wait_done(lat);
        chk("min/1 lo", lo, MIN); chk("min/1 hi", hi, 32'd0);
        tick();

        // restart attempt and operand change while busy are ignored
        start_op(32'd100, 32'd7);
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd5; end
            if (c == 11) start = 1'b0;
            tick();
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("restart latency", c, 32'd33);
                    chk("100/7 lo", lo, 32'd14);
                    chk("100/7 hi", hi, 32'd2);
                end
            end
        end
        chk("single done", ndone, 32'd1);

        // asynchronous reset mid-run
        start_op(32'd1000, 32'd3);
        repeat (14) tick();
        #1 reset = 1'b0;
        #1;
        chk("async busy", {31'd0, busy}, 32'd0);
        chk("async hi", hi, 32'd0);
        chk("async lo", lo, 32'd0);
        chk("async done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        start_op(32'd9, 32'd3); wait_done(lat);
        chk("9/3 latency", lat, 32'd33);
        chk("9/3 lo", lo, 32'd3); chk("9/3 hi", hi, 32'd0);

        // randomized traffic with noise while busy; model checks each cycle
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom % 3) tick();
            start_op(rand_opnd(), rand_opnd());
            lat = 0;
            while (!done && lat < 100) begin
                dividend = $urandom;
                divisor  = $urandom;
                start    = ($urandom % 4 == 0);
                tick();
                lat++;
            end
            start = 1'b0;
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout: got no done within %0d cycles", lat);
            end
        end

        tick(); tick();
        en_cmp = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
